// File: rtl/rca32_bit_full_adder_pkg.sv
// ============================================================================
// Module      : rca32_bit_full_adder_pkg
// Description : Shared constants for the ripple-carry adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rca32_bit_full_adder_pkg;
  localparam int ADDER_WIDTH = 32;
endpackage

`default_nettype wire

// File: rtl/rca32_bit_full_adder_full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : One-bit full-adder cell, purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

`default_nettype wire

// File: rtl/rca32_bit_full_adder.sv
// ============================================================================
// Module      : rca32_bit_full_adder
// Description : WIDTH-bit ripple-carry adder with a single registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca32_bit_full_adder
  import rca32_bit_full_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             ca
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             ca_d;
  logic             ca_q;

  assign c[0] = cin;

  // Carry ripples strictly from cell i to cell i+1; no lookahead by design.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a_i    (a[i]),
      .b_i    (b[i]),
      .cin_i  (c[i]),
      .s_o    (s[i]),
      .cout_o (c[i+1])
    );
  end

  always_comb begin
    sum_d = s;
    ca_d  = c[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      ca_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ca_q  <= ca_d;
    end
  end

  assign sum = sum_q;
  assign ca  = ca_q;

endmodule

`default_nettype wire

// File: tb/tb_rca32_bit_full_adder.sv
// ============================================================================
// Module      : tb_rca32_bit_full_adder
// Description : Directed and random self-checking bench for the ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rca32_bit_full_adder;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         ca;

  int vectors;
  int miscompares;

  rca32_bit_full_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .ca    (ca)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      if (k == 1) begin
        a = 'x;
        b = 'x;
        cin = 1'bx;
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({ca, sum} !== 33'd0) begin
        miscompares++;
        $display("FAIL reset[%0d]: got ca=%b sum=%h, expected ca=0 sum=0", k, ca, sum);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_small_sums();
    logic [W-1:0] ta [5] = '{32'd5, 32'd14, 32'd17, 32'd19, 32'd2};
    logic [W-1:0] tb [5] = '{32'd8, 32'd5,  32'd10, 32'd8,  32'd21};
    logic [W-1:0] te [5] = '{32'd13, 32'd19, 32'd27, 32'd27, 32'd23};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = ta[k]; b = tb[k]; cin = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (sum !== te[k] || ca !== 1'b0) begin
        miscompares++;
        $display("FAIL small[%0d]: got ca=%b sum=%0d, expected ca=0 sum=%0d", k, ca, sum, te[k]);
      end
    end
  endtask

  task automatic test_carry_in();
    @(negedge clk);
    a = 32'h0; b = 32'h0; cin = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (sum !== 32'h1 || ca !== 1'b0) begin
      miscompares++;
      $display("FAIL cin_zero: got ca=%b sum=%h, expected ca=0 sum=00000001", ca, sum);
    end
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (sum !== 32'h0 || ca !== 1'b1) begin
      miscompares++;
      $display("FAIL cin_wrap: got ca=%b sum=%h, expected ca=1 sum=00000000", ca, sum);
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (sum !== 32'h0 || ca !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap: got ca=%b sum=%h, expected ca=1 sum=00000000", ca, sum);
    end
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (sum !== 32'hFFFF_FFFF || ca !== 1'b1) begin
      miscompares++;
      $display("FAIL max: got ca=%b sum=%h, expected ca=1 sum=ffffffff", ca, sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [6] = '{32'h0000_0001, 32'h8000_0000, 32'h1234_5678, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 32'h7FFF_FFFF};
    logic [W-1:0] tb [6] = '{32'h0000_0002, 32'h8000_0000, 32'h1111_1111, 32'hF0F0_F0F0, 32'h5555_5555, 32'h0000_0000};
    logic         tc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W:0]   te [6] = '{33'h0_0000_0003, 33'h1_0000_0000, 33'h0_2345_678A,
                             33'h1_0000_0000, 33'h0_FFFF_FFFF, 33'h0_8000_0000};
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        vectors++;
        if ({ca, sum} !== te[k-1]) begin
          miscompares++;
          $display("FAIL b2b[%0d]: got %h, expected %h", k-1, {ca, sum}, te[k-1]);
        end
      end
      if (k < 6) begin
        a = ta[k]; b = tb[k]; cin = tc[k];
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 32'd100; b = 32'd23; cin = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ({ca, sum} !== 33'd123) begin
      miscompares++;
      $display("FAIL mid_pre: got %h, expected %h", {ca, sum}, 33'd123);
    end
    @(negedge clk);
    rst_n = 1'b0;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({ca, sum} !== 33'd0) begin
      miscompares++;
      $display("FAIL mid_rst: got %h, expected 0", {ca, sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'd40; b = 32'd2; cin = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({ca, sum} !== 33'd43) begin
      miscompares++;
      $display("FAIL mid_post: got %h, expected %h", {ca, sum}, 33'd43);
    end
  endtask

  task automatic test_random();
    logic [W:0] exp_prev;
    logic [W:0] exp_cur;
    exp_prev = '0;
    for (int k = 0; k <= 10000; k++) begin
      @(negedge clk);
      if (k > 0) begin
        vectors++;
        if ({ca, sum} !== exp_prev) begin
          miscompares++;
          $display("FAIL rand[%0d]: got %h, expected %h", k-1, {ca, sum}, exp_prev);
        end
      end
      if (k < 10000) begin
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        exp_cur  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        exp_prev = exp_cur;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    test_reset();
    test_small_sums();
    test_carry_in();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
